// File: rtl/alu_serial_driver_if.sv
// Request/result handshake bundle for the bit-serial ALU front-end.
// master = requester/consumer side, slave = alu_serial_driver.
interface alu_serial_driver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sel;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op_a, op_b, op_sel, res_ready,
        input  in_ready, res_valid, result
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sel, res_ready,
        output in_ready, res_valid, result
    );
endinterface

// File: rtl/alu_serial_driver.sv
// Bit-serial front-end for the 1-bit sum_alu: shifts operands out LSB first,
// collects the ALU's out bit per cycle and hands the assembled word back.
module alu_serial_driver #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_serial_driver_if.slave   bus,
    output logic                 alu_a,
    output logic                 alu_b,
    output logic                 alu_s,
    input  logic                 alu_out,
    output logic                 busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r,     state_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    logic [WIDTH-1:0] sh_a_r,      sh_a_s;
    logic [WIDTH-1:0] sh_b_r,      sh_b_s;
    logic [WIDTH-1:0] result_r,    result_s;
    logic             sel_q_r,     sel_q_s;
    logic             alu_s_r,     alu_s_s;
    logic             in_ready_r,  in_ready_s;
    logic             busy_r,      busy_s;
    logic             res_valid_r, res_valid_s;

    // State and datapath registers; everything visible outside is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            sh_a_r      <= {WIDTH{1'b0}};
            sh_b_r      <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            sel_q_r     <= 1'b0;
            alu_s_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            sh_a_r      <= sh_a_s;
            sh_b_r      <= sh_b_s;
            result_r    <= result_s;
            sel_q_r     <= sel_q_s;
            alu_s_r     <= alu_s_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            res_valid_r <= res_valid_s;
        end
    end

    // Next-state and next-register computation for IDLE -> SHIFT -> DONE.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        sh_a_s      = sh_a_r;
        sh_b_s      = sh_b_r;
        result_s    = result_r;
        sel_q_s     = sel_q_r;
        alu_s_s     = alu_s_r;
        in_ready_s  = in_ready_r;
        busy_s      = busy_r;
        res_valid_s = res_valid_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    state_s    = ST_SHIFT;
                    sh_a_s     = bus.op_a;
                    sh_b_s     = bus.op_b;
                    sel_q_s    = bus.op_sel;
                    alu_s_s    = bus.op_sel;
                    cnt_s      = {CNT_W{1'b0}};
                    result_s   = {WIDTH{1'b0}};
                    in_ready_s = 1'b0;
                    busy_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Zero-fill on the shift so alu_a/alu_b read 0 once the word is drained.
                result_s[cnt_r] = alu_out;
                sh_a_s          = {1'b0, sh_a_r[WIDTH-1:1]};
                sh_b_s          = {1'b0, sh_b_r[WIDTH-1:1]};
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s     = ST_DONE;
                    alu_s_s     = 1'b0;
                    res_valid_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_s     = ST_IDLE;
                    res_valid_s = 1'b0;
                    busy_s      = 1'b0;
                    in_ready_s  = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = {CNT_W{1'b0}};
                sh_a_s      = {WIDTH{1'b0}};
                sh_b_s      = {WIDTH{1'b0}};
                alu_s_s     = 1'b0;
                in_ready_s  = 1'b1;
                busy_s      = 1'b0;
                res_valid_s = 1'b0;
            end
        endcase
    end

    assign alu_a         = sh_a_r[0];
    assign alu_b         = sh_b_r[0];
    assign alu_s         = alu_s_r;
    assign busy          = busy_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.result    = result_r;
endmodule

// File: tb/tb_alu_serial_driver.sv
// Self-checking bench for alu_serial_driver (WIDTH=8) with a 1-bit ALU stub,
// a result scoreboard and a latency queue.
module tb_alu_serial_driver;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic alu_a, alu_b, alu_s, alu_out, busy;

    alu_serial_driver_if #(.WIDTH(W)) bus ();

    alu_serial_driver #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_s   (alu_s),
        .alu_out (alu_out),
        .busy    (busy)
    );

    assign alu_out = alu_s ? (alu_a & alu_b) : (alu_a ^ alu_b);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb[$];
    int lat_q[$];
    int acc_cnt = 0;
    int seq_n = 0;
    logic [31:0] seq_bits = 32'd0;
    logic prev_rv = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sel;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts accepts, records serial bits, checks latency and results.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (busy && !bus.res_valid && seq_n < 32) begin
                seq_bits[seq_n] = alu_a;
                seq_n++;
            end
            if (bus.res_valid && !prev_rv) begin
                if (lat_q.size() == 0) check("spurious_res_valid", 32'd1, 32'd0);
                else check("latency", 32'(cyc - lat_q.pop_front()), 32'd8);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) check("unexpected_result", 32'd1, 32'd0);
                else check("result", 32'(bus.result), 32'(sb.pop_front()));
            end
        end
        prev_rv = bus.res_valid;
    end

    task automatic wait_accept(input logic [W-1:0] exp, output int edge_no);
        edge_no = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready && bus.in_valid) begin
                edge_no = cyc + 1;
                sb.push_back(exp);
                lat_q.push_back(edge_no);
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sel, input logic [W-1:0] exp);
        int e;
        bus.op_a = a; bus.op_b = b; bus.op_sel = sel; bus.in_valid = 1'b1;
        wait_accept(exp, e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.res_valid) begin
                @(posedge clk); #1;
                return;
            end
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int e1, e2, acc0;
        bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_sel = 1'b0;
        bus.res_ready = 1'b1;

        vecs[0] = '{8'h12, 8'h34, 1'b0, 8'h26};
        vecs[1] = '{8'hFF, 8'h81, 1'b1, 8'h81};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h81};
        vecs[3] = '{8'hC3, 8'h3C, 1'b1, 8'h00};
        vecs[4] = '{8'h5A, 8'hFF, 1'b0, 8'hA5};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF};

        // T1: reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_s", 32'(alu_s), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;

        // T2: XOR with serial bit order check
        seq_n = 0;
        do_op(8'hA5, 8'h0F, 1'b0, 8'hAA);
        wait_done();
        check("t2_shift_cycles", 32'(seq_n), 32'd8);
        check("t2_alu_a_seq", 32'(seq_bits[7:0]), 32'h0000_00A5);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp);
            wait_done();
        end

        // T3: AND with backpressure
        bus.res_ready = 1'b0;
        do_op(8'hF0, 8'h3C, 1'b1, 8'h30);
        for (int i = 0; i < 20 && !bus.res_valid; i++) @(negedge clk);
        check("t3_valid_seen", 32'(bus.res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.res_valid), 32'd1);
            check("t3_hold_result", 32'(bus.result), 32'h30);
            check("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        wait_done();

        // T4: request pulsed during SHIFT is ignored
        acc0 = acc_cnt;
        do_op(8'h3C, 8'h0F, 1'b0, 8'h33);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op_a = 8'hFF; bus.op_b = 8'hFF; bus.op_sel = 1'b1;
        @(negedge clk);
        check("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done();
        check("t4_accepts", 32'(acc_cnt - acc0), 32'd1);

        // T5: reset on the 4th SHIFT cycle aborts the operation
        do_op(8'h55, 8'h00, 1'b0, 8'h55);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        lat_q.delete();
        check("t5_abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_result", 32'(bus.result), 32'd0);
        check("t5_abort_alu_s", 32'(alu_s), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_no_valid_after", 32'(bus.res_valid), 32'd0);
        check("t5_result_zero", 32'(bus.result), 32'd0);
        @(posedge clk); #1;
        do_op(8'h01, 8'h01, 1'b0, 8'h00);
        wait_done();

        // T6: back-to-back with in_valid and res_ready held high
        bus.res_ready = 1'b1;
        bus.op_a = 8'hC3; bus.op_b = 8'h5A; bus.op_sel = 1'b0; bus.in_valid = 1'b1;
        wait_accept(8'h99, e1);
        @(posedge clk); #1;
        bus.op_a = 8'hF0; bus.op_b = 8'hFF; bus.op_sel = 1'b1;
        wait_accept(8'hF0, e2);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("t6_accept_spacing", 32'(e2 - e1), 32'd10);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
